wb_regfile: RTL and testbench



---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_regfile_load_extract.sv | 39 +++
 rtl/wb_regfile.sv | 96 +++++++++
 tb/tb_wb_regfile.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback / register-file slice.
// Optional feature macro: WB_RETIRE_CNT_EN (retired-instruction counter).
package wb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

endpackage

// File: rtl/wb_regfile_load_extract.sv
// Load data extraction: picks byte/half/word from the aligned
// memory word by byte offset and sign- or zero-extends it.
module load_extract
    import wb_pkg::*;
(
    input  logic [31:0] dm_out,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Byte and halfword lane selection by address offset
    always_comb begin
        byte_sel = dm_out[7:0];
        unique case (off)
            2'd0: byte_sel = dm_out[7:0];
            2'd1: byte_sel = dm_out[15:8];
            2'd2: byte_sel = dm_out[23:16];
            2'd3: byte_sel = dm_out[31:24];
        endcase
        half_sel = off[1] ? dm_out[31:16] : dm_out[15:0];
    end

    // Width/sign decode; unknown codes fall back to a full word
    always_comb begin
        value = dm_out;
        case (func3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {24'h0, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value = {16'h0, half_sel};
            default: value = dm_out;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: load extraction, integer register file with
// write-through read bypass, halt FSM. Option: WB_RETIRE_CNT_EN.
module wb_regfile
    import wb_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     dm_out_i,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [4:0]      rd_index_i,
    input  logic            wb_sel_i,
    input  logic            wb_en_i,
    input  logic [2:0]      func3_i,
    input  logic            halt_i,
    input  logic [4:0]      rs1_index_i,
    input  logic [4:0]      rs2_index_i,
    output logic [XLEN-1:0] rs1_data_o,
    output logic [XLEN-1:0] rs2_data_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic            halted_o
`ifdef WB_RETIRE_CNT_EN
    ,
    output logic [63:0]     retire_cnt_o
`endif
);

    state_t          state;
    logic            we;
    logic [31:0]     load_val;
    logic [XLEN-1:0] regs [NREG];

    load_extract u_load_extract (
        .dm_out (dm_out_i),
        .off    (alu_out_i[1:0]),
        .func3  (func3_i),
        .value  (load_val)
    );

    assign wb_data_o = wb_sel_i ? load_val : alu_out_i;
    assign we        = wb_en_i && (rd_index_i != 5'd0)
                       && (state != HALTED);
    assign halted_o  = (state == HALTED);

    // Reads see the value being written this cycle (bypass)
    assign rs1_data_o =
        (rs1_index_i == 5'd0) ? '0 :
        (we && rs1_index_i == rd_index_i) ? wb_data_o :
        regs[rs1_index_i];

    assign rs2_data_o =
        (rs2_index_i == 5'd0) ? '0 :
        (we && rs2_index_i == rd_index_i) ? wb_data_o :
        regs[rs2_index_i];

    // Register array; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[rd_index_i] <= wb_data_o;
        end
    end

    // Halt FSM: a halt retires once, then state is frozen until reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            unique case (state)
                RUN:    if (halt_i) state <= HALTED;
                HALTED: state <= HALTED;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;

    // Count valid WB slots while running; wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt <= '0;
        end else if (state == RUN && (wb_en_i || halt_i)) begin
            retire_cnt <= retire_cnt + 64'd1;
        end
    end

    assign retire_cnt_o = retire_cnt;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile against a behavioural model.
// Optional counter checks when WB_RETIRE_CNT_EN is defined.
module tb_wb_regfile;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] dm_out = '0;
    logic [31:0] alu_out = '0;
    logic [4:0]  rd_index = '0;
    logic        wb_sel = 1'b0;
    logic        wb_en = 1'b0;
    logic [2:0]  func3 = '0;
    logic        halt = 1'b0;
    logic [4:0]  rs1_index = '0;
    logic [4:0]  rs2_index = '0;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] wb_data;
    logic        halted;
`ifdef WB_RETIRE_CNT_EN
    logic [63:0] retire_cnt;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] m_regs [32];
    bit          m_halted;
    logic [63:0] m_cnt;

    logic [2:0]  lf3 [5];
    logic [1:0]  loff [5];
    logic [31:0] lexp [5];

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk         (clk),
        .rst         (rst),
        .dm_out_i    (dm_out),
        .alu_out_i   (alu_out),
        .rd_index_i  (rd_index),
        .wb_sel_i    (wb_sel),
        .wb_en_i     (wb_en),
        .func3_i     (func3),
        .halt_i      (halt),
        .rs1_index_i (rs1_index),
        .rs2_index_i (rs2_index),
        .rs1_data_o  (rs1_data),
        .rs2_data_o  (rs2_data),
        .wb_data_o   (wb_data),
        .halted_o    (halted)
`ifdef WB_RETIRE_CNT_EN
        ,
        .retire_cnt_o(retire_cnt)
`endif
    );

    function automatic logic [31:0] ref_load(input logic [31:0] dm,
                                             input logic [1:0] off,
                                             input logic [2:0] f3);
        logic [31:0] b;
        logic [31:0] h;
        b = (dm >> (8 * off)) & 32'hFF;
        h = (dm >> (16 * off[1])) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
            3'b100:  return b;
            3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'b101:  return h;
            default: return dm;
        endcase
    endfunction

    function automatic logic [31:0] exp_wb();
        return wb_sel ? ref_load(dm_out, alu_out[1:0], func3) : alu_out;
    endfunction

    function automatic bit writes_now();
        return !m_halted && wb_en && rd_index != 5'd0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
        if (writes_now() && idx == rd_index) return exp_wb();
        return m_regs[idx];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_comb();
        check("wb_data", {32'h0, wb_data}, {32'h0, exp_wb()});
        check("rs1", {32'h0, rs1_data}, {32'h0, exp_read(rs1_index)});
        check("rs2", {32'h0, rs2_data}, {32'h0, exp_read(rs2_index)});
        check("halted", {63'h0, halted}, {63'h0, m_halted});
`ifdef WB_RETIRE_CNT_EN
        check("retire", retire_cnt, m_cnt);
`endif
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_halted = 1'b0;
        m_cnt = 64'h0;
    endtask

    task automatic tick();
        bit          do_w;
        bit          valid;
        bit          h;
        logic [4:0]  rd;
        logic [31:0] v;
        do_w  = writes_now();
        v     = exp_wb();
        rd    = rd_index;
        valid = !m_halted && (wb_en || halt);
        h     = halt;
        @(posedge clk);
        #1;
        if (do_w) m_regs[rd] = v;
        if (valid) m_cnt = m_cnt + 64'd1;
        if (h) m_halted = 1'b1;
    endtask

    task automatic set_alu(input logic [4:0] rd, input logic [31:0] v,
                           input logic en, input logic h);
        wb_sel = 1'b0;
        alu_out = v;
        rd_index = rd;
        wb_en = en;
        halt = h;
    endtask

    task automatic async_reset();
        #3;
        wb_en = 1'b0;
        halt = 1'b0;
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_halted", {63'h0, halted}, 64'h0);
        for (int i = 0; i < 4; i++) begin
            rs1_index = 5'($urandom_range(1, 31));
            rs2_index = 5'($urandom_range(1, 31));
            #1;
            check("rst_rs1", {32'h0, rs1_data}, 64'h0);
            check_comb();
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
    endtask

    initial begin
        lf3  = '{F3_LB, F3_LBU, F3_LH, F3_LHU, F3_LW};
        loff = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        lexp = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1,
                 32'h00007F02, 32'h80F17F02};
        model_reset();

        rs1_index = 5'd1;
        rs2_index = 5'd31;
        #2;
        check_comb();
        @(negedge clk);
        rst = 1'b1;
        #1;

        // Random traffic, no halts
        for (int n = 0; n < 300; n++) begin
            dm_out   = $urandom;
            alu_out  = $urandom;
            rd_index = 5'($urandom_range(0, 31));
            wb_sel   = 1'($urandom);
            wb_en    = ($urandom_range(0, 3) != 0);
            func3    = 3'($urandom_range(0, 7));
            halt     = 1'b0;
            rs1_index = ($urandom_range(0, 2) == 0) ? rd_index
                        : 5'($urandom_range(0, 31));
            rs2_index = ($urandom_range(0, 2) == 0) ? rd_index
                        : 5'($urandom_range(0, 31));
            #1;
            check_comb();
            tick();
            check_comb();
        end

        // Reset with live register contents
        async_reset();

        // x0 is hardwired
        set_alu(5'd0, 32'hDEADBEEF, 1'b1, 1'b0);
        rs1_index = 5'd0;
        rs2_index = 5'd0;
        #1;
        check("x0_byp", {32'h0, rs1_data}, 64'h0);
        tick();
        wb_en = 1'b0;
        #1;
        check("x0_read", {32'h0, rs1_data}, 64'h0);

        // Load extraction table
        for (int i = 0; i < 5; i++) begin
            dm_out    = 32'h80F17F02;
            alu_out   = {30'h04000000, loff[i]};
            func3     = lf3[i];
            wb_sel    = 1'b1;
            wb_en     = 1'b1;
            rd_index  = 5'd5;
            rs1_index = 5'd5;
            rs2_index = 5'd0;
            #1;
            check("ld_wb", {32'h0, wb_data}, {32'h0, lexp[i]});
            check_comb();
            tick();
            wb_en = 1'b0;
            #1;
            check("ld_x5", {32'h0, rs1_data}, {32'h0, lexp[i]});
            check_comb();
        end

        // Dual-port bypass then stored read
        set_alu(5'd7, 32'h12345678, 1'b1, 1'b0);
        rs1_index = 5'd7;
        rs2_index = 5'd7;
        #1;
        check("byp_rs1", {32'h0, rs1_data}, 64'h12345678);
        check("byp_rs2", {32'h0, rs2_data}, 64'h12345678);
        tick();
        wb_en = 1'b0;
        #1;
        check("st_rs1", {32'h0, rs1_data}, 64'h12345678);
        check("st_rs2", {32'h0, rs2_data}, 64'h12345678);

        // Halt with a same-cycle write
        set_alu(5'd3, 32'h55, 1'b1, 1'b1);
        rs1_index = 5'd3;
        rs2_index = 5'd7;
        #1;
        check_comb();
        tick();
        halt = 1'b0;
        wb_en = 1'b0;
        #1;
        check("halt_flag", {63'h0, halted}, 64'h1);
        check("halt_x3", {32'h0, rs1_data}, 64'h55);
        set_alu(5'd3, 32'hAA, 1'b1, 1'b0);
        #1;
        check("halt_nobyp", {32'h0, rs1_data}, 64'h55);
        check_comb();
        tick();
        check("halt_frozen", {32'h0, rs1_data}, 64'h55);
        check_comb();

        // Asynchronous reset while halted
        async_reset();
        set_alu(5'd9, 32'h0BADF00D, 1'b1, 1'b0);
        rs1_index = 5'd9;
        tick();
        wb_en = 1'b0;
        #1;
        check("post_rst_wr", {32'h0, rs1_data}, 64'h0BADF00D);
        check_comb();

        // Ten valid instructions then a halt
        async_reset();
        for (int n = 0; n < 10; n++) begin
            set_alu(5'($urandom_range(1, 31)), $urandom, 1'b1, 1'b0);
            rs1_index = rd_index;
            #1;
            check_comb();
            tick();
        end
        set_alu(5'd0, 32'h0, 1'b0, 1'b1);
        tick();
        halt = 1'b0;
        for (int n = 0; n < 5; n++) begin
            set_alu(5'd4, $urandom, 1'b1, 1'b0);
            #1;
            check_comb();
`ifdef WB_RETIRE_CNT_EN
            check("retire_11", retire_cnt, 64'd11);
`endif
            tick();
        end
        check_comb();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
